// File: rtl/ccip_tx_fifo_pkg.sv
// Shared types and constants for the CCI-P transmit FIFO.
package ccip_tx_fifo_pkg;

    typedef struct packed {
        logic [15:0] rpc_id;
        logic [15:0] method_id;
        logic [31:0] arg;
    } RpcIf;

    localparam int CCIP_TX_FIFO_LDEPTH_DFLT = 4;

    function automatic int fifo_depth(input int ldepth);
        return 2 ** ldepth;
    endfunction

endpackage

// File: rtl/ccip_tx_fifo_if.sv
// Handshake bundle between the RPC pipeline / CCI-P side (master) and the FIFO (slave).
interface ccip_tx_fifo_if
    import ccip_tx_fifo_pkg::*;
#(
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LDEPTH            = CCIP_TX_FIFO_LDEPTH_DFLT
);
    logic                         start;
    RpcIf                         rpc_in;
    logic                         rpc_in_valid;
    logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in;
    logic                         rpc_in_ready;
    logic                         ccip_tx_ready;
    RpcIf                         rpc_out;
    logic                         rpc_out_valid;
    logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out;
    logic [LDEPTH:0]              fifo_level;
    logic                         overflow;

    modport master (
        output start, rpc_in, rpc_in_valid, rpc_flow_id_in, ccip_tx_ready,
        input  rpc_in_ready, rpc_out, rpc_out_valid, rpc_flow_id_out, fifo_level, overflow
    );

    modport slave (
        input  start, rpc_in, rpc_in_valid, rpc_flow_id_in, ccip_tx_ready,
        output rpc_in_ready, rpc_out, rpc_out_valid, rpc_flow_id_out, fifo_level, overflow
    );

endinterface

// File: rtl/ccip_tx_fifo_mem.sv
// Simple dual-port RAM with a one-cycle registered read; the array itself is never reset.
module ccip_tx_fifo_mem #(
    parameter int WIDTH  = 65,
    parameter int LDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [LDEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [LDEPTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem_q [2**LDEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register only loads on a pop, so the output holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ccip_tx_fifo.sv
// NIC->CPU write-back FIFO draining into the CCI-P polling path while ccip_tx_ready is high.
// Optional drop counter / high watermark outputs are built when CCIP_TX_FIFO_STATS_EN is defined.
module ccip_tx_fifo
    import ccip_tx_fifo_pkg::*;
#(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LDEPTH            = CCIP_TX_FIFO_LDEPTH_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    ccip_tx_fifo_if.slave     bus
`ifdef CCIP_TX_FIFO_STATS_EN
    ,
    output logic [31:0]       drop_cnt,
    output logic [LDEPTH:0]   max_level
`endif
);
    typedef struct packed {
        logic [LMAX_NUM_OF_FLOWS-1:0] flow_id;
        RpcIf                         rpc;
    } entry_t;

    localparam int              DEPTH     = fifo_depth(LDEPTH);
    localparam logic [LDEPTH:0] DEPTH_CNT = {1'b1, {LDEPTH{1'b0}}};

    if (LDEPTH < 1 || NIC_ID < 0 || DEPTH < 2) begin : g_param_check
        $error("ccip_tx_fifo: illegal parameters");
    end

    logic [LDEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LDEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LDEPTH:0]   count_q, count_d;
    logic              valid_q, overflow_q;
    logic              pop, push, drop;
    entry_t            wr_entry, rd_entry;

    // A push into a full FIFO is still accepted when a pop frees a slot the same cycle.
    always_comb begin
        pop      = bus.start && bus.ccip_tx_ready && (count_q != '0);
        push     = bus.rpc_in_valid && ((count_q != DEPTH_CNT) || pop);
        drop     = bus.rpc_in_valid && !push;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wr_entry.flow_id = bus.rpc_flow_id_in;
        wr_entry.rpc     = bus.rpc_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= pop;
            overflow_q <= drop;
        end
    end

    ccip_tx_fifo_mem #(
        .WIDTH  ($bits(entry_t)),
        .LDEPTH (LDEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    assign bus.rpc_in_ready    = (count_q != DEPTH_CNT);
    assign bus.rpc_out         = rd_entry.rpc;
    assign bus.rpc_flow_id_out = rd_entry.flow_id;
    assign bus.rpc_out_valid   = valid_q;
    assign bus.fifo_level      = count_q;
    assign bus.overflow        = overflow_q;

`ifdef CCIP_TX_FIFO_STATS_EN
    logic [31:0]     drop_cnt_q;
    logic [LDEPTH:0] max_level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q  <= '0;
            max_level_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (count_q > max_level_q) begin
                max_level_q <= count_q;
            end
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_ccip_tx_fifo.sv
// Directed, table-driven bench for ccip_tx_fifo plus hand-written reset and stats sequences.
module tb_ccip_tx_fifo;
    import ccip_tx_fifo_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ccip_tx_fifo_if #(.LMAX_NUM_OF_FLOWS(1), .LDEPTH(4)) bus ();

`ifdef CCIP_TX_FIFO_STATS_EN
    logic [31:0] drop_cnt;
    logic [4:0]  max_level;
`endif

    ccip_tx_fifo #(
        .NIC_ID            (0),
        .LMAX_NUM_OF_FLOWS (1),
        .LDEPTH            (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef CCIP_TX_FIFO_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .max_level (max_level)
`endif
    );

    typedef struct {
        string name;
        logic  st;
        logic  vld;
        logic  rdy;
        int    k_in;
        logic  ev;
        int    k_out;
        int    lvl;
        logic  ovf;
        logic  irdy;
    } vec_t;

    vec_t vecs[$];

    // Entry k carries a distinctive payload; k < 0 means "reset value".
    function automatic logic [63:0] dv(input int k);
        logic [15:0] kk;
        if (k < 0) return 64'h0;
        kk = k[15:0];
        return {16'hC0DE, kk, ~kk, 16'(k * 3)};
    endfunction

    function automatic logic fl(input int k);
        if (k < 0) return 1'b0;
        return k[0];
    endfunction

    function automatic void add(input string name, input logic st, input logic vld, input logic rdy,
                                input int k_in, input logic ev, input int k_out, input int lvl,
                                input logic ovf, input logic irdy);
        vec_t v;
        v.name = name; v.st = st; v.vld = vld; v.rdy = rdy; v.k_in = k_in;
        v.ev = ev; v.k_out = k_out; v.lvl = lvl; v.ovf = ovf; v.irdy = irdy;
        vecs.push_back(v);
    endfunction

    task automatic check_row(input string name, input logic ev, input int k_out, input int lvl,
                             input logic ovf, input logic irdy);
        logic [63:0] act_d;
        act_d = bus.rpc_out;
        total++;
        if (bus.rpc_out_valid === ev && act_d === dv(k_out) && bus.rpc_flow_id_out === fl(k_out) &&
            bus.fifo_level === 5'(lvl) && bus.overflow === ovf && bus.rpc_in_ready === irdy) begin
            passed++;
            $display("%s: v=%0b f=%0d d=%h lvl=%0d ovf=%0b rdy=%0b ok", name, bus.rpc_out_valid,
                     bus.rpc_flow_id_out, act_d, bus.fifo_level, bus.overflow, bus.rpc_in_ready);
        end else begin
            $display("FAIL %s: got v=%0b f=%0d d=%h lvl=%0d ovf=%0b rdy=%0b, expected v=%0b f=%0d d=%h lvl=%0d ovf=%0b rdy=%0b",
                     name, bus.rpc_out_valid, bus.rpc_flow_id_out, act_d, bus.fifo_level, bus.overflow,
                     bus.rpc_in_ready, ev, fl(k_out), dv(k_out), lvl, ovf, irdy);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("%s: %0d ok", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.start          = v.st;
        bus.rpc_in_valid   = v.vld;
        bus.rpc_in         = dv(v.k_in);
        bus.rpc_flow_id_in = fl(v.k_in);
        bus.ccip_tx_ready  = v.rdy;
        @(posedge clk);
        #1;
        check_row(v.name, v.ev, v.k_out, v.lvl, v.ovf, v.irdy);
    endtask

    task automatic drive(input logic st, input logic vld, input logic rdy, input int k_in,
                         input string name, input logic ev, input int k_out, input int lvl,
                         input logic irdy);
        vec_t v;
        v.name = name; v.st = st; v.vld = vld; v.rdy = rdy; v.k_in = k_in;
        v.ev = ev; v.k_out = k_out; v.lvl = lvl; v.ovf = 1'b0; v.irdy = irdy;
        apply(v);
    endtask

    initial begin
        // Test 1: single entry latency
        add("t1_push", 1, 1, 1, 0, 0, -1, 1, 0, 1);
        add("t1_pop",  1, 0, 1, 0, 1,  0, 0, 0, 1);
        add("t1_hold", 1, 0, 1, 0, 0,  0, 0, 0, 1);
        // Test 2: fill to full, drop the 17th, drain in order
        for (int k = 1; k <= 16; k++) add("t2_fill", 1, 1, 0, k, 0, 0, k, 0, k < 16);
        add("t2_drop",  1, 1, 0, 17, 0, 0, 16, 1, 0);
        add("t2_after", 1, 0, 0, 0,  0, 0, 16, 0, 0);
        for (int j = 1; j <= 16; j++) add("t2_drain", 1, 0, 1, 0, 1, j, 16 - j, 0, 1);
        add("t2_idle", 1, 0, 1, 0, 0, 16, 0, 0, 1);
        // Test 3: full FIFO with push and pop every cycle
        for (int k = 20; k <= 35; k++) add("t3_fill", 1, 1, 0, k, 0, 16, k - 19, 0, (k - 19) < 16);
        for (int m = 1; m <= 8; m++) add("t3_thru", 1, 1, 1, 35 + m, 1, 19 + m, 16, 0, 0);
        for (int n = 1; n <= 16; n++) add("t3_drain", 1, 0, 1, 0, 1, 27 + n, 16 - n, 0, 1);
        add("t3_idle", 1, 0, 1, 0, 0, 43, 0, 0, 1);
        // Test 4: start low holds pops
        for (int k = 50; k <= 54; k++) add("t4_fill", 0, 1, 1, k, 0, 43, k - 49, 0, 1);
        add("t4_hold", 0, 0, 1, 0, 0, 43, 5, 0, 1);
        for (int n = 1; n <= 5; n++) add("t4_drain", 1, 0, 1, 0, 1, 49 + n, 5 - n, 0, 1);
        add("t4_idle", 1, 0, 1, 0, 0, 54, 0, 0, 1);
        // Test 5: ready toggling, then 20 pointer wraps streaming one entry per cycle
        for (int k = 60; k <= 67; k++) add("t5_fill", 1, 1, 0, k, 0, 54, k - 59, 0, 1);
        for (int t = 0; t < 16; t++)
            add("t5_toggle", 1, 0, (t % 2) == 0, 0, (t % 2) == 0, 60 + t / 2, 8 - (t / 2 + 1), 0, 1);
        for (int k = 100; k < 420; k++)
            add("t5_wrap", 1, 1, 1, k, k > 100, (k > 100) ? k - 1 : 67, 1, 0, 1);
        add("t5_last", 1, 0, 1, 0, 1, 419, 0, 0, 1);

        reset_n            = 1'b0;
        bus.start          = 1'b0;
        bus.rpc_in_valid   = 1'b0;
        bus.rpc_in         = '0;
        bus.rpc_flow_id_in = '0;
        bus.ccip_tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_row("reset", 0, -1, 0, 0, 1);
`ifdef CCIP_TX_FIFO_STATS_EN
        check_val("reset_drop_cnt", drop_cnt, 32'd0);
        check_val("reset_max_level", 32'(max_level), 32'd0);
`endif
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Test 6: asynchronous reset in the middle of a drain
        for (int k = 500; k <= 508; k++) drive(1, 1, 0, k, "t6_fill", 0, 419, k - 499, 1);
        drive(1, 0, 1, 0, "t6_drain", 1, 500, 8, 1);
        drive(1, 0, 1, 0, "t6_drain", 1, 501, 7, 1);
`ifdef CCIP_TX_FIFO_STATS_EN
        check_val("stats_drop_cnt", drop_cnt, 32'd1);
        check_val("stats_max_level", 32'(max_level), 32'd16);
`endif
        #3 reset_n = 1'b0;
        #1;
        check_row("t6_async", 0, -1, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        check_row("t6_held", 0, -1, 0, 0, 1);
        #4 reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_row("t6_post", 0, -1, 0, 0, 1);
        end
`ifdef CCIP_TX_FIFO_STATS_EN
        check_val("t6_drop_cnt", drop_cnt, 32'd0);
        check_val("t6_max_level", 32'(max_level), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
